// File: rtl/ring_barrier_multi_pkg.sv
// ring_barrier_multi_pkg: slot code, op encodings and FSM states shared by the barrier unit
package ring_barrier_multi_pkg;
  localparam logic [3:0] SLOT_BARRIER = 4'hA;
  typedef enum logic [1:0] {
    OP_ARRIVE_WAIT = 2'b00,
    OP_ARRIVE_ONLY = 2'b01,
    OP_WAIT_ONLY   = 2'b10,
    OP_RSVD        = 2'b11
  } bar_op_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TOKEN,
    S_WAIT_GEN,
    S_DONE
  } bar_state_e;
endpackage

// File: rtl/ring_barrier_multi_channel.sv
// ring_barrier_multi_channel: one barrier channel, arrival counter plus wrapping generation
module ring_barrier_multi_channel #(
  parameter int CNT_W = 5,
  parameter int GEN_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_hit,
  input  logic [CNT_W-1:0] i_thr,
  output logic [GEN_W-1:0] o_gen_next
);
  logic [CNT_W-1:0] r_cnt;
  logic [GEN_W-1:0] r_gen;
  logic [CNT_W:0]   w_need;
  logic [CNT_W:0]   w_inc;
  logic             w_complete;
  always_comb begin
    w_need     = (i_thr == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, i_thr};
    w_inc      = {1'b0, r_cnt} + 1'b1;
    w_complete = i_hit && (w_inc >= w_need);
    o_gen_next = w_complete ? r_gen + 1'b1 : r_gen;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_gen <= '0;
    end else if (i_hit) begin
      r_cnt <= w_complete ? '0 : w_inc[CNT_W-1:0];
      r_gen <= o_gen_next;
    end
  end
endmodule

// File: rtl/ring_barrier_multi.sv
// ring_barrier_multi: multi-channel split-phase ring barrier, FSM and ring drive over NBAR channels
module ring_barrier_multi
  import ring_barrier_multi_pkg::*;
#(
  parameter int NBAR  = 4,
  parameter int CNT_W = 5,
  parameter int GEN_W = 2,
  localparam int ID_W = $clog2(NBAR)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             selBarrier,
  input  logic [1:0]       barOp,
  input  logic [ID_W-1:0]  barId,
  input  logic [CNT_W-1:0] barThresh,
  input  logic [3:0]       whichCore,
  output logic             done,
  output logic             error,
  input  logic [31:0]      RingIn,
  input  logic [3:0]       SlotTypeIn,
  input  logic [3:0]       SourceIn,
  output logic [31:0]      barrierRingOut,
  output logic [3:0]       barrierSlotTypeOut,
  output logic [3:0]       barrierSourceOut,
  output logic             barrierDriveRing,
  output logic             barrierWantsToken,
  input  logic             barrierAcquireToken
);
  bar_state_e       r_state;
  bar_op_e          r_op;
  logic [ID_W-1:0]  r_id;
  logic [CNT_W-1:0] r_thr;
  logic [GEN_W-1:0] r_rec_gen;
  logic             r_pend;
  logic [ID_W-1:0]  r_pend_id;
  logic [GEN_W-1:0] r_pend_gen;
  logic             r_error;
  logic [ID_W-1:0]  w_ring_id;
  logic [CNT_W-1:0] w_ring_thr;
  logic             w_slot;
  logic             w_id_ok;
  logic             w_unused;
  logic [GEN_W-1:0] w_gen_next [NBAR];
  assign w_ring_id  = RingIn[ID_W-1:0];
  assign w_ring_thr = RingIn[ID_W+CNT_W-1:ID_W];
  assign w_slot     = (SlotTypeIn == SLOT_BARRIER) && (32'(w_ring_id) < NBAR);
  assign w_id_ok    = 32'(barId) < NBAR;
  assign w_unused   = ^{RingIn[31:ID_W+CNT_W], SourceIn};
  for (genvar c = 0; c < NBAR; c++) begin : g_ch
    ring_barrier_multi_channel #(.CNT_W(CNT_W), .GEN_W(GEN_W)) u_ch (
      .clock      (clock),
      .reset      (reset),
      .i_hit      (w_slot && (w_ring_id == ID_W'(c))),
      .i_thr      (w_ring_thr),
      .o_gen_next (w_gen_next[c])
    );
  end
  // Generation compares use the post-update value so done follows the completing slot by one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_ARRIVE_WAIT;
      r_id       <= '0;
      r_thr      <= '0;
      r_rec_gen  <= '0;
      r_pend     <= 1'b0;
      r_pend_id  <= '0;
      r_pend_gen <= '0;
      r_error    <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: if (selBarrier) begin
          r_op  <= bar_op_e'(barOp);
          r_id  <= barId;
          r_thr <= barThresh;
          if (barOp == OP_RSVD || !w_id_ok) begin
            r_state <= S_DONE;
            r_error <= 1'b1;
          end else if (barOp == OP_WAIT_ONLY) begin
            if (!r_pend || r_pend_id != barId) begin
              r_state <= S_DONE;
              r_error <= 1'b1;
            end else begin
              r_rec_gen <= r_pend_gen;
              r_state   <= S_WAIT_GEN;
            end
          end else r_state <= S_WAIT_TOKEN;
        end
        S_WAIT_TOKEN: if (barrierAcquireToken) begin
          if (r_op == OP_ARRIVE_ONLY) begin
            r_pend     <= 1'b1;
            r_pend_id  <= r_id;
            r_pend_gen <= w_gen_next[r_id];
            r_state    <= S_DONE;
          end else begin
            r_rec_gen <= w_gen_next[r_id];
            r_state   <= S_WAIT_GEN;
          end
        end
        S_WAIT_GEN: if (w_gen_next[r_id] != r_rec_gen) begin
          r_state <= S_DONE;
          if (r_op == OP_WAIT_ONLY) r_pend <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign done               = r_state == S_DONE;
  assign error              = r_error;
  assign barrierWantsToken  = r_state == S_WAIT_TOKEN;
  assign barrierDriveRing   = barrierWantsToken & barrierAcquireToken;
  assign barrierRingOut     = {{(32-ID_W-CNT_W){1'b0}}, r_thr, r_id};
  assign barrierSlotTypeOut = SLOT_BARRIER;
  assign barrierSourceOut   = whichCore;
endmodule

// File: tb/tb_ring_barrier_multi.sv
// tb_ring_barrier_multi: randomized scenario bench for ring_barrier_multi against a channel-level model
module tb_ring_barrier_multi;
  import ring_barrier_multi_pkg::*;
  localparam int NBAR = 4, CNT_W = 5, GEN_W = 2, ID_W = 2;
  logic clock = 1'b0, reset = 1'b1, selBarrier = 1'b0;
  logic [1:0] barOp = '0;
  logic [ID_W-1:0] barId = '0;
  logic [CNT_W-1:0] barThresh = '0;
  logic [3:0] whichCore = 4'd6;
  logic done, error;
  logic [31:0] RingIn = '0;
  logic [3:0] SlotTypeIn = '0, SourceIn = '0;
  logic [31:0] barrierRingOut;
  logic [3:0] barrierSlotTypeOut, barrierSourceOut;
  logic barrierDriveRing, barrierWantsToken, barrierAcquireToken = 1'b0;
  int errors = 0, checks = 0;
  int m_cnt [NBAR];
  int m_gen [NBAR];
  logic [CNT_W-1:0] p_cnt [NBAR];
  logic [GEN_W-1:0] p_gen [NBAR];

  ring_barrier_multi #(.NBAR(NBAR), .CNT_W(CNT_W), .GEN_W(GEN_W)) dut (
    .clock(clock), .reset(reset), .selBarrier(selBarrier), .barOp(barOp), .barId(barId),
    .barThresh(barThresh), .whichCore(whichCore), .done(done), .error(error), .RingIn(RingIn),
    .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn), .barrierRingOut(barrierRingOut),
    .barrierSlotTypeOut(barrierSlotTypeOut), .barrierSourceOut(barrierSourceOut),
    .barrierDriveRing(barrierDriveRing), .barrierWantsToken(barrierWantsToken),
    .barrierAcquireToken(barrierAcquireToken)
  );

  assign p_cnt[0] = dut.g_ch[0].u_ch.r_cnt;
  assign p_cnt[1] = dut.g_ch[1].u_ch.r_cnt;
  assign p_cnt[2] = dut.g_ch[2].u_ch.r_cnt;
  assign p_cnt[3] = dut.g_ch[3].u_ch.r_cnt;
  assign p_gen[0] = dut.g_ch[0].u_ch.r_gen;
  assign p_gen[1] = dut.g_ch[1].u_ch.r_gen;
  assign p_gen[2] = dut.g_ch[2].u_ch.r_gen;
  assign p_gen[3] = dut.g_ch[3].u_ch.r_gen;

  always #5 clock = ~clock;

  task automatic model_clear();
    for (int i = 0; i < NBAR; i++) begin
      m_cnt[i] = 0;
      m_gen[i] = 0;
    end
  endtask

  task automatic model_slot(input int id, input int thr);
    int need;
    need = (thr == 0) ? 1 : thr;
    if (id < NBAR) begin
      if (m_cnt[id] + 1 >= need) begin
        m_cnt[id] = 0;
        m_gen[id] = (m_gen[id] + 1) % (1 << GEN_W);
      end else m_cnt[id] = m_cnt[id] + 1;
    end
  endtask

  task automatic cyc(input bit v, input int id, input int thr, input bit g);
    SlotTypeIn = v ? SLOT_BARRIER : 4'h3;
    RingIn = v ? ((32'(thr) << ID_W) | 32'(id) | (32'($urandom) << (ID_W + CNT_W))) : 32'($urandom);
    SourceIn = 4'($urandom);
    barrierAcquireToken = g;
    @(posedge clock);
    if (v) model_slot(id, thr);
    #1;
    SlotTypeIn = '0;
    selBarrier = 1'b0;
    barrierAcquireToken = 1'b0;
  endtask

  task automatic issue(input int op, input int id, input int thr);
    selBarrier = 1'b1;
    barOp = 2'(op);
    barId = ID_W'(id);
    barThresh = CNT_W'(thr);
    cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc(1'b0, 0, 0, 1'b0);
    reset = 1'b0;
    model_clear();
    checks++;
    if ({done, error, barrierWantsToken, barrierDriveRing} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {done, error, barrierWantsToken, barrierDriveRing});
    end
    checks++;
    if (barrierSlotTypeOut !== SLOT_BARRIER || barrierSourceOut !== whichCore) begin
      errors++;
      $display("FAIL reset_slot_fields: got type %h src %h expected %h %h", barrierSlotTypeOut, barrierSourceOut, SLOT_BARRIER, whichCore);
    end
    for (int i = 0; i < NBAR; i++) begin
      checks++;
      if (p_cnt[i] !== '0 || p_gen[i] !== '0) begin
        errors++;
        $display("FAIL reset_channel%0d: got cnt %0d gen %0d expected 0 0", i, p_cnt[i], p_gen[i]);
      end
    end
  endtask

  task automatic wait_done(input string name, input int id, input int thr, input int rec, input bit idle_mix);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 64 && !hit; n++) begin
      if (idle_mix && ($urandom % 3 == 0)) begin
        selBarrier = $urandom % 2;
        barOp = 2'b11;
        cyc(1'b0, 0, 0, 1'b0);
      end else cyc(1'b1, id, thr, 1'b0);
      hit = (m_gen[id] != rec);
      checks++;
      if (done !== hit || error !== 1'b0) begin
        errors++;
        $display("FAIL %s_done: got done %b err %b expected done %b err 0", name, done, error, hit);
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s_budget: got no completion expected completion within 64 cycles", name);
    end
    cyc(1'b0, 0, 0, 1'b0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: got done %b expected 0", name, done);
    end
  endtask

  task automatic test_arrive_wait(input int id, input int thr);
    int rec;
    issue(OP_ARRIVE_WAIT, id, thr);
    repeat ($urandom_range(0, 3)) cyc(1'b0, 0, 0, 1'b0);
    checks++;
    if (barrierWantsToken !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL aw_want: got want %b done %b expected 1 0", barrierWantsToken, done);
    end
    barrierAcquireToken = 1'b1;
    #1;
    checks++;
    if (barrierDriveRing !== 1'b1 || barrierRingOut !== 32'((thr << ID_W) | id)) begin
      errors++;
      $display("FAIL aw_drive: got drive %b data %h expected 1 %h", barrierDriveRing, barrierRingOut, 32'((thr << ID_W) | id));
    end
    cyc(1'b0, 0, 0, 1'b1);
    rec = m_gen[id];
    checks++;
    if (barrierWantsToken !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL aw_granted: got want %b done %b expected 0 0", barrierWantsToken, done);
    end
    wait_done("arrive_wait", id, thr, rec, 1'b1);
  endtask

  task automatic test_interleave();
    int rec;
    int g0;
    bit hit;
    int seq [3] = '{0, 2, 0};
    issue(OP_ARRIVE_WAIT, 2, 2);
    cyc(1'b0, 0, 0, 1'b1);
    rec = m_gen[2];
    g0 = m_gen[0];
    hit = 1'b0;
    for (int n = 0; n < 64 && !hit; n++) begin
      int id;
      id = (n < 3) ? seq[n] : (($urandom % 2) ? 0 : 2);
      cyc(1'b1, id, 2, 1'b0);
      hit = (m_gen[2] != rec);
      checks++;
      if (done !== hit) begin
        errors++;
        $display("FAIL interleave_done: got %b expected %b after slot id %0d", done, hit, id);
      end
    end
    checks++;
    if (int'(p_gen[0]) !== m_gen[0] || int'(p_gen[2]) !== m_gen[2] || m_gen[0] == g0) begin
      errors++;
      $display("FAIL interleave_gens: got gen0 %0d gen2 %0d expected %0d %0d", p_gen[0], p_gen[2], m_gen[0], m_gen[2]);
    end
    cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_split();
    int pend;
    int pend0;
    bit hit;
    issue(OP_ARRIVE_ONLY, 3, 3);
    checks++;
    if (barrierWantsToken !== 1'b1) begin
      errors++;
      $display("FAIL split_want: got %b expected 1", barrierWantsToken);
    end
    cyc(1'b0, 0, 0, 1'b1);
    pend = m_gen[3];
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL split_arrive_done: got done %b err %b expected 1 0", done, error);
    end
    cyc(1'b0, 0, 0, 1'b0);
    issue(OP_WAIT_ONLY, 0, 0);
    checks++;
    if (done !== 1'b1 || error !== 1'b1) begin
      errors++;
      $display("FAIL split_wrong_id: got done %b err %b expected 1 1", done, error);
    end
    for (int n = 0; n < 40 && m_gen[3] == pend; n++) begin
      cyc(1'b1, 3, 3, 1'b0);
      checks++;
      if (done !== 1'b0 || barrierWantsToken !== 1'b0) begin
        errors++;
        $display("FAIL split_idle: got done %b want %b expected 0 0", done, barrierWantsToken);
      end
    end
    issue(OP_WAIT_ONLY, 3, 0);
    checks++;
    if (done !== 1'b0 || barrierWantsToken !== 1'b0) begin
      errors++;
      $display("FAIL split_wait_entry: got done %b want %b expected 0 0", done, barrierWantsToken);
    end
    cyc(1'b0, 0, 0, 1'b0);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL split_wait_done: got done %b err %b expected 1 0", done, error);
    end
    cyc(1'b0, 0, 0, 1'b0);
    issue(OP_WAIT_ONLY, 3, 0);
    checks++;
    if (done !== 1'b1 || error !== 1'b1) begin
      errors++;
      $display("FAIL split_rewait: got done %b err %b expected 1 1", done, error);
    end
    cyc(1'b0, 0, 0, 1'b0);
    issue(OP_ARRIVE_ONLY, 0, 2);
    cyc(1'b0, 0, 0, 1'b1);
    pend0 = m_gen[0];
    cyc(1'b0, 0, 0, 1'b0);
    issue(OP_WAIT_ONLY, 0, 0);
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      cyc(1'b1, 0, 2, 1'b0);
      hit = (m_gen[0] != pend0);
      checks++;
      if (done !== hit || error !== 1'b0) begin
        errors++;
        $display("FAIL split_blocking_wait: got done %b err %b expected %b 0", done, error, hit);
      end
    end
    cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_same_cycle(input int id, input int thr);
    int rec;
    for (int n = 0; n < 40 && (m_cnt[id] + 1 < thr); n++) cyc(1'b1, id, thr, 1'b0);
    issue(OP_ARRIVE_WAIT, id, thr);
    cyc(1'b1, id, thr, 1'b1);
    rec = m_gen[id];
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_grant: got done %b expected 0", done);
    end
    cyc(1'b0, 0, 0, 1'b0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_hold: got done %b expected 0", done);
    end
    wait_done("same_cycle", id, thr, rec, 1'b0);
  endtask

  task automatic test_bad_op();
    issue(OP_RSVD, $urandom % NBAR, $urandom % 8);
    checks++;
    if (done !== 1'b1 || error !== 1'b1 || barrierWantsToken !== 1'b0) begin
      errors++;
      $display("FAIL bad_op: got done %b err %b want %b expected 1 1 0", done, error, barrierWantsToken);
    end
    cyc(1'b0, 0, 0, 1'b0);
    checks++;
    if (done !== 1'b0 || error !== 1'b0 || barrierWantsToken !== 1'b0) begin
      errors++;
      $display("FAIL bad_op_after: got done %b err %b want %b expected 0 0 0", done, error, barrierWantsToken);
    end
  endtask

  task automatic test_reset_mid();
    issue(OP_ARRIVE_WAIT, 2, 4);
    cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b1, 0, 5, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 0, 0, 1'b0);
    reset = 1'b0;
    model_clear();
    checks++;
    if ({done, error, barrierWantsToken, barrierDriveRing} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected 0000", {done, error, barrierWantsToken, barrierDriveRing});
    end
    cyc(1'b1, 2, 4, 1'b0);
    repeat (3) begin
      cyc(1'b1, 2, 4, 1'b0);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_done: got %b expected 0", done);
      end
    end
  endtask

  task automatic test_counters();
    for (int i = 0; i < NBAR; i++) begin
      checks++;
      if (int'(p_cnt[i]) !== m_cnt[i] || int'(p_gen[i]) !== m_gen[i]) begin
        errors++;
        $display("FAIL counters%0d: got cnt %0d gen %0d expected %0d %0d", i, p_cnt[i], p_gen[i], m_cnt[i], m_gen[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arrive_wait(1, 3);
    test_counters();
    test_interleave();
    test_split();
    test_counters();
    test_same_cycle(1, $urandom_range(2, 4));
    test_bad_op();
    test_arrive_wait(0, 0);
    for (int k = 0; k < 4; k++) test_arrive_wait($urandom % NBAR, $urandom_range(1, 6));
    test_counters();
    test_reset_mid();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run expected finish before 2000000");
    $fatal(1);
  end
endmodule
